matrix_pipe_ctrl: RTL and testbench

Pipeline control unit for the 5-stage core with the matrix extension. It sits beside the ID/EX pipeline register and generates its flush, plus the PC and IF/ID stall and flush controls. It resolves three cases: load-use hazards, taken-branch flushes, and multi-row matrix operations (row load, row store, MOPA accumulate). For a multi-row operation it holds the instruction in ID, sequences per-row transfers over a ready handshake, then releases the instruction into EX.

---
 rtl/matrix_pipe_ctrl.sv | 133 +++++++++++++
 tb/tb_matrix_pipe_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/matrix_pipe_ctrl.sv
// Pipeline control for the 5-stage core with matrix extension: load-use stalls, branch flushes
// and multi-row matrix op sequencing (row load/store over a ready handshake, mopa accumulate).
module matrix_pipe_ctrl #(
  parameter int unsigned ROWS        = 4,
  parameter int unsigned MOPA_CYCLES = 4,
  parameter int unsigned CNT_W       = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_mem2matrix,
  input  logic             id_matrix2mem,
  input  logic             id_matrix_write_mopa,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_br_taken,
  input  logic             mem_ready,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mx_req,
  output logic             mx_store,
  output logic [CNT_W-1:0] mx_row_idx,
  output logic             mx_busy,
  output logic             mx_done
);

  typedef enum logic [2:0] {StIdle, StLoad, StStore, StMopa, StDone} state_e;

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;

  logic w_load_use;
  logic w_mx_op;
  logic w_last_row;
  logic w_last_step;

  assign w_load_use  = ex_mem_read && (ex_rd != 5'd0) &&
                       ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  assign w_mx_op     = id_mem2matrix || id_matrix2mem || id_matrix_write_mopa;
  assign w_last_row  = (r_cnt == CNT_W'(ROWS - 1));
  assign w_last_step = (r_cnt == CNT_W'(MOPA_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          // Branch and load-use both outrank a matrix op; it triggers on a later cycle.
          if (!ex_br_taken && !w_load_use && w_mx_op) begin
            r_cnt <= '0;
            if (id_mem2matrix)      r_state <= StLoad;
            else if (id_matrix2mem) r_state <= StStore;
            else                    r_state <= StMopa;
          end
        end
        StLoad, StStore: begin
          if (mem_ready) begin
            if (w_last_row) begin
              r_cnt   <= '0;
              r_state <= StDone;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        StMopa: begin
          if (w_last_step) begin
            r_cnt   <= '0;
            r_state <= StDone;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  always_comb begin
    pc_stall    = 1'b0;
    if_id_stall = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    mx_req      = 1'b0;
    mx_store    = 1'b0;
    mx_row_idx  = '0;
    mx_busy     = 1'b0;
    mx_done     = 1'b0;
    if (rst) begin
      case (r_state)
        StIdle: begin
          if (ex_br_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (w_load_use || w_mx_op) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
          end
        end
        StLoad, StStore: begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_flush = 1'b1;
          mx_req      = 1'b1;
          mx_store    = (r_state == StStore);
          mx_row_idx  = r_cnt;
          mx_busy     = 1'b1;
        end
        StMopa: begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_flush = 1'b1;
          mx_row_idx  = r_cnt;
          mx_busy     = 1'b1;
        end
        StDone: begin
          // Stalls drop so the held instruction enters ID/EX at this edge.
          mx_busy = 1'b1;
          mx_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_pipe_ctrl.sv
// Scoreboard bench for matrix_pipe_ctrl: per-cycle expected output vectors are queued as stimulus
// is applied and compared at the falling edge.
module tb_matrix_pipe_ctrl;

  localparam int unsigned CNT_W = 3;

  logic             clk;
  logic             rst;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_mem2matrix;
  logic             id_matrix2mem;
  logic             id_matrix_write_mopa;
  logic [4:0]       ex_rd;
  logic             ex_mem_read;
  logic             ex_br_taken;
  logic             mem_ready;
  logic             pc_stall;
  logic             if_id_stall;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             mx_req;
  logic             mx_store;
  logic [CNT_W-1:0] mx_row_idx;
  logic             mx_busy;
  logic             mx_done;

  matrix_pipe_ctrl #(
    .ROWS        (4),
    .MOPA_CYCLES (4),
    .CNT_W       (CNT_W)
  ) u_dut (
    .clk                  (clk),
    .rst                  (rst),
    .id_rs1               (id_rs1),
    .id_rs2               (id_rs2),
    .id_mem2matrix        (id_mem2matrix),
    .id_matrix2mem        (id_matrix2mem),
    .id_matrix_write_mopa (id_matrix_write_mopa),
    .ex_rd                (ex_rd),
    .ex_mem_read          (ex_mem_read),
    .ex_br_taken          (ex_br_taken),
    .mem_ready            (mem_ready),
    .pc_stall             (pc_stall),
    .if_id_stall          (if_id_stall),
    .if_id_flush          (if_id_flush),
    .id_ex_flush          (id_ex_flush),
    .mx_req               (mx_req),
    .mx_store             (mx_store),
    .mx_row_idx           (mx_row_idx),
    .mx_busy              (mx_busy),
    .mx_done              (mx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc_stall, if_id_stall, if_id_flush, id_ex_flush}
  localparam logic [3:0] CtlNone  = 4'b0000;
  localparam logic [3:0] CtlStall = 4'b1101;
  localparam logic [3:0] CtlFlush = 4'b0011;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [10:0] sb_q[$];
  logic [10:0] w_obs;

  assign w_obs = {pc_stall, if_id_stall, if_id_flush, id_ex_flush,
                  mx_req, mx_store, mx_row_idx, mx_busy, mx_done};

  function automatic logic [10:0] mk(input logic [3:0] ctl, input logic req, input logic st,
                                     input logic [2:0] idx, input logic busy, input logic done);
    return {ctl, req, st, idx, busy, done};
  endfunction

  task automatic check_eq(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got ctl=%b req=%b st=%b idx=%0d busy=%b done=%b, want ctl=%b req=%b st=%b idx=%0d busy=%b done=%b",
               tag, obs[10:7], obs[6], obs[5], obs[4:2], obs[1], obs[0],
               exp[10:7], exp[6], exp[5], exp[4:2], exp[1], exp[0]);
    end
  endtask

  // Queue the expectation for this cycle's inputs, then check what the DUT presents.
  task automatic tick(input string tag, input logic [10:0] exp);
    logic [10:0] want;
    sb_q.push_back(exp);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      want = sb_q.pop_front();
      check_eq(tag, w_obs, want);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_mem2matrix = 1'b0; id_matrix2mem = 1'b0; id_matrix_write_mopa = 1'b0;
    ex_mem_read = 1'b0; ex_br_taken = 1'b0; mem_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    clr();
    @(posedge clk);
    #1;

    // Reset forces outputs low despite active inputs.
    id_mem2matrix = 1'b1; ex_br_taken = 1'b1; mem_ready = 1'b1;
    ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3;
    tick("rst_noise0", '0);
    tick("rst_noise1", '0);
    clr();
    rst = 1'b1;
    tick("idle_after_rst", '0);

    // Load-use.
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5;
    tick("lu_rs2", mk(CtlStall, 0, 0, 0, 0, 0));
    ex_mem_read = 1'b0;
    tick("lu_release", '0);
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    tick("lu_x0", '0);
    ex_rd = 5'd7; id_rs1 = 5'd7; id_rs2 = 5'd9;
    tick("lu_rs1", mk(CtlStall, 0, 0, 0, 0, 0));
    ex_rd = 5'd8;
    tick("lu_nomatch", '0);
    clr();

    // Branch beats load-use and matrix op.
    ex_br_taken = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_mem2matrix = 1'b1;
    tick("br_flush", mk(CtlFlush, 0, 0, 0, 0, 0));
    clr();
    tick("br_stays_idle", '0);

    // Load-use delays a matrix load; then load runs (mopa also set, load wins).
    id_mem2matrix = 1'b1; id_matrix_write_mopa = 1'b1; mem_ready = 1'b1;
    ex_mem_read = 1'b1; ex_rd = 5'd4; id_rs1 = 5'd4;
    tick("ld_lu_hold", mk(CtlStall, 0, 0, 0, 0, 0));
    ex_mem_read = 1'b0;
    tick("ld_trig", mk(CtlStall, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) tick("ld_row", mk(CtlStall, 1, 0, 3'(i), 1, 0));
    tick("ld_done", mk(CtlNone, 0, 0, 0, 1, 1));
    clr();
    tick("ld_idle", '0);

    // Store with back-pressure at row 2 (mopa also set, store wins).
    id_matrix2mem = 1'b1; id_matrix_write_mopa = 1'b1; mem_ready = 1'b1;
    tick("st_trig", mk(CtlStall, 0, 0, 0, 0, 0));
    tick("st_row0", mk(CtlStall, 1, 1, 3'd0, 1, 0));
    tick("st_row1", mk(CtlStall, 1, 1, 3'd1, 1, 0));
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick("st_row2_wait", mk(CtlStall, 1, 1, 3'd2, 1, 0));
    mem_ready = 1'b1;
    tick("st_row2_go", mk(CtlStall, 1, 1, 3'd2, 1, 0));
    tick("st_row3", mk(CtlStall, 1, 1, 3'd3, 1, 0));
    id_mem2matrix = 1'b1;
    tick("st_done_noretrig", mk(CtlNone, 0, 0, 0, 1, 1));
    clr();
    tick("st_idle", '0);

    // Mopa ignores mem_ready.
    id_matrix_write_mopa = 1'b1;
    tick("mopa_trig", mk(CtlStall, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) tick("mopa_step", mk(CtlStall, 0, 0, 3'(i), 1, 0));
    tick("mopa_done", mk(CtlNone, 0, 0, 0, 1, 1));
    clr();
    tick("mopa_idle", '0);

    // Reset mid-load at row 2: no done pulse afterwards, counter restarts at 0.
    id_mem2matrix = 1'b1; mem_ready = 1'b1;
    tick("rl_trig", mk(CtlStall, 0, 0, 0, 0, 0));
    tick("rl_row0", mk(CtlStall, 1, 0, 3'd0, 1, 0));
    tick("rl_row1", mk(CtlStall, 1, 0, 3'd1, 1, 0));
    rst = 1'b0;
    tick("rl_rst", '0);
    rst = 1'b1;
    clr();
    tick("rl_after0", '0);
    tick("rl_after1", '0);
    id_mem2matrix = 1'b1; mem_ready = 1'b1;
    tick("rl_retrig", mk(CtlStall, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) tick("rl_row", mk(CtlStall, 1, 0, 3'(i), 1, 0));
    tick("rl_done", mk(CtlNone, 0, 0, 0, 1, 1));
    clr();
    tick("rl_idle", '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
